packed_occupancy_grid: RTL and testbench

Bit-packed occupancy grid controller: stores one occupancy bit per grid cell, packing 2^DATA_WIDTH_LOG2 cells per word of an external single-port synchronous BRAM. Supports single-cell read, single-cell write via read-modify-write, and a whole-grid clear sweep. Maintains a running count of occupied cells. Sits between the RRT collision checker / map loader and the BRAM; it is the generalised successor to the one-cell-per-word occupancy grid.

---
 rtl/packed_occupancy_grid_pkg.sv | 16 +
 rtl/packed_occupancy_grid.sv | 126 ++++++++++++
 tb/tb_packed_occupancy_grid.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/packed_occupancy_grid_pkg.sv
// packed_occupancy_grid_pkg: opcode and FSM state types for the packed occupancy grid
package packed_occupancy_grid_pkg;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_CLEAR_ALL = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CLEAR
    } state_t;

endpackage

// File: rtl/packed_occupancy_grid.sv
// packed_occupancy_grid: one occupancy bit per cell, packed into BRAM words, with RMW writes, clear sweep and live count
module packed_occupancy_grid
    import packed_occupancy_grid_pkg::*;
#(
    parameter int GRID_WIDTH_LOG2 = 6,
    parameter int GRID_HEIGHT_LOG2 = 6,
    parameter int DATA_WIDTH_LOG2 = 5,
    localparam int IDX_W = GRID_WIDTH_LOG2 + GRID_HEIGHT_LOG2,
    localparam int ADDR_WIDTH = IDX_W - DATA_WIDTH_LOG2,
    localparam int DATA_W = 1 << DATA_WIDTH_LOG2,
    localparam int CNT_W = IDX_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [GRID_WIDTH_LOG2-1:0]  cell_x_in,
    input  logic [GRID_HEIGHT_LOG2-1:0] cell_y_in,
    input  logic [1:0]                  op_in,
    input  logic                        w_occupied,
    input  logic                        vld_in,
    output logic                        rdy,
    output logic                        vld_out,
    output logic                        r_occupied,
    output logic [CNT_W-1:0]            occupied_count,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    state_t                     state, state_next;
    logic                       is_write_q;
    logic                       wocc_q;
    logic [DATA_WIDTH_LOG2-1:0] bit_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [ADDR_WIDTH-1:0]      sweep;
    logic [IDX_W-1:0]           idx;
    logic                       accept;
    logic                       old_bit;
    logic                       sweep_done;

    assign idx        = {cell_y_in, cell_x_in};
    assign accept     = (state == IDLE) && vld_in;
    assign old_bit    = mem_rdata[bit_q];
    assign sweep_done = (sweep == '1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and BRAM port drive; the read address goes out combinationally on accept
    always_comb begin
        state_next = state;
        rdy        = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (vld_in) begin
                    if (op_in == OP_CLEAR_ALL) begin
                        state_next = CLEAR;
                    end else begin
                        state_next = ACCESS;
                        mem_addr   = idx[IDX_W-1:DATA_WIDTH_LOG2];
                    end
                end
            end
            ACCESS: begin
                state_next = IDLE;
                if (is_write_q) begin
                    mem_we           = 1'b1;
                    mem_addr         = addr_q;
                    mem_wdata        = mem_rdata;
                    mem_wdata[bit_q] = wocc_q;
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = sweep;
                if (sweep_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, sweep counter, result and occupancy count bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_q     <= 1'b0;
            wocc_q         <= 1'b0;
            bit_q          <= '0;
            addr_q         <= '0;
            sweep          <= '0;
            vld_out        <= 1'b0;
            r_occupied     <= 1'b0;
            occupied_count <= '0;
        end else begin
            vld_out <= 1'b0;
            if (accept) begin
                is_write_q <= (op_in == OP_WRITE);
                wocc_q     <= w_occupied;
                bit_q      <= idx[DATA_WIDTH_LOG2-1:0];
                addr_q     <= idx[IDX_W-1:DATA_WIDTH_LOG2];
                sweep      <= '0;
            end
            if (state == ACCESS) begin
                r_occupied <= old_bit;
                vld_out    <= 1'b1;
                if (is_write_q && (old_bit != wocc_q))
                    occupied_count <= wocc_q ? occupied_count + CNT_W'(1) : occupied_count - CNT_W'(1);
            end
            if (state == CLEAR) begin
                sweep <= sweep + ADDR_WIDTH'(1);
                if (sweep_done) begin
                    occupied_count <= '0;
                    r_occupied     <= 1'b0;
                    vld_out        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_packed_occupancy_grid.sv
// tb_packed_occupancy_grid: directed checks of the packed occupancy grid on an 8x8 grid with 8-bit BRAM words
module tb_packed_occupancy_grid;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cell_x_in = '0;
    logic [2:0] cell_y_in = '0;
    logic [1:0] op_in = '0;
    logic       w_occupied = 1'b0;
    logic       vld_in = 1'b0;
    logic       rdy;
    logic       vld_out;
    logic       r_occupied;
    logic [6:0] occupied_count;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;

    logic [7:0] mem [8];

    int vectors = 0;
    int miscompares = 0;
    int we_cnt;
    int nz_cnt;

    packed_occupancy_grid #(
        .GRID_WIDTH_LOG2(3),
        .GRID_HEIGHT_LOG2(3),
        .DATA_WIDTH_LOG2(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cell_x_in(cell_x_in),
        .cell_y_in(cell_y_in),
        .op_in(op_in),
        .w_occupied(w_occupied),
        .vld_in(vld_in),
        .rdy(rdy),
        .vld_out(vld_out),
        .r_occupied(r_occupied),
        .occupied_count(occupied_count),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port read-first synchronous BRAM
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge, then wait (bounded) for vld_out; lat counts cycles after accept
    task automatic do_op(input logic [1:0] op, input int x, input int y, input logic w,
                         output logic r, output int lat);
        logic [2:0] xs, ys;
        xs = x[2:0];
        ys = y[2:0];
        @(negedge clk);
        op_in = op;
        cell_x_in = xs;
        cell_y_in = ys;
        w_occupied = w;
        vld_in = 1'b1;
        check("rdy_at_req", rdy, 1);
        @(posedge clk);
        #1 vld_in = 1'b0;
        lat = -1;
        r = 1'bx;
        we_cnt = 0;
        nz_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (mem_we && mem_wdata != 0) nz_cnt++;
            if (vld_out) begin
                lat = i;
                r = r_occupied;
                break;
            end
        end
    endtask

    logic [1:0] seq_op [8];
    logic [2:0] seq_x [8];
    logic       exp_r [8];

    initial begin
        logic r;
        int   lat;
        int   acc, vcnt, last, bad, vlds;
        logic take;
        logic [7:0] orw;

        for (int i = 0; i < 8; i++) mem[i] = 8'hA5;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_vld_out", vld_out, 0);
        check("rst_r_occupied", r_occupied, 0);
        check("rst_count", occupied_count, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        // CLEAR_ALL: 8 zero writes, completion in cycle 9, single pulse
        do_op(2'd2, 0, 0, 1'b0, r, lat);
        check("clr_latency", lat, 9);
        check("clr_we_cycles", we_cnt, 8);
        check("clr_nonzero_wdata", nz_cnt, 0);
        check("clr_r_occupied", r, 0);
        check("clr_count", occupied_count, 0);
        @(negedge clk);
        check("clr_vld_single", vld_out, 0);
        orw = '0;
        for (int i = 0; i < 8; i++) orw |= mem[i];
        check("clr_mem_zero", orw, 0);

        // WRITE (3,5)=1 then reads
        do_op(2'd1, 3, 5, 1'b1, r, lat);
        check("wr35_latency", lat, 2);
        check("wr35_r_old", r, 0);
        check("wr35_count", occupied_count, 1);
        check("wr35_word5", mem[5], 8'h08);
        do_op(2'd0, 3, 5, 1'b0, r, lat);
        check("rd35_val", r, 1);
        check("rd35_count", occupied_count, 1);
        do_op(2'd0, 4, 5, 1'b0, r, lat);
        check("rd45_val", r, 0);
        do_op(2'd3, 3, 5, 1'b1, r, lat);
        check("reserved_as_read", r, 1);
        check("reserved_count", occupied_count, 1);
        check("reserved_word5", mem[5], 8'h08);

        // Repeat write of a set cell, then clear it
        do_op(2'd1, 3, 5, 1'b1, r, lat);
        check("wr35_again_r", r, 1);
        check("wr35_again_count", occupied_count, 1);
        do_op(2'd1, 3, 5, 1'b0, r, lat);
        check("wr35_zero_r", r, 1);
        check("wr35_zero_count", occupied_count, 0);
        check("wr35_zero_word5", mem[5], 8'h00);

        // vld_in held high: requests only taken on rdy cycles, bogus CLEAR_ALL shown while busy
        for (int i = 0; i < 8; i++) begin
            seq_op[i] = (i % 2 == 0) ? 2'd1 : 2'd0;
            seq_x[i]  = 3'(i / 2);
            exp_r[i]  = (i % 2 == 1);
        end
        acc = 0; vcnt = 0; last = -1; bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (vld_out) begin
                if (vcnt < 8) check($sformatf("burst_r%0d", vcnt), r_occupied, exp_r[vcnt]);
                if (last >= 0 && cyc - last != 2) bad++;
                last = cyc;
                vcnt++;
            end
            if (acc < 8) begin
                vld_in = 1'b1;
                op_in = rdy ? seq_op[acc] : 2'd2;
                cell_x_in = seq_x[acc];
                cell_y_in = 3'd0;
                w_occupied = 1'b1;
            end else begin
                vld_in = 1'b0;
            end
            take = vld_in && rdy;
            @(posedge clk);
            if (take) acc++;
        end
        check("burst_accepts", acc, 8);
        check("burst_vld_count", vcnt, 8);
        check("burst_spacing_errors", bad, 0);
        check("burst_count", occupied_count, 4);
        check("burst_word0", mem[0], 8'h0F);

        // Fill all 64 cells, then clear
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                do_op(2'd1, x, y, 1'b1, r, lat);
        check("fill_count", occupied_count, 64);
        orw = '1;
        for (int i = 0; i < 8; i++) orw &= mem[i];
        check("fill_mem_ones", orw, 8'hFF);
        do_op(2'd2, 0, 0, 1'b0, r, lat);
        check("fill_clr_count", occupied_count, 0);
        check("fill_clr_latency", lat, 9);

        // Reset in the middle of a CLEAR sweep
        do_op(2'd1, 3, 5, 1'b1, r, lat);
        do_op(2'd0, 3, 5, 1'b0, r, lat);
        check("pre_rst_r", r, 1);
        check("pre_rst_count", occupied_count, 1);
        @(negedge clk);
        op_in = 2'd2;
        vld_in = 1'b1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_clr_busy", rdy, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_rdy", rdy, 1);
        check("mrst_vld_out", vld_out, 0);
        check("mrst_r_occupied", r_occupied, 0);
        check("mrst_count", occupied_count, 0);
        check("mrst_mem_we", mem_we, 0);
        check("mrst_mem_addr", mem_addr, 0);
        check("mrst_mem_wdata", mem_wdata, 0);
        vlds = 0;
        repeat (2) begin
            @(negedge clk);
            if (vld_out) vlds++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (vld_out) vlds++;
        end
        check("mrst_no_vld", vlds, 0);
        check("mrst_rdy_after", rdy, 1);
        do_op(2'd0, 3, 5, 1'b0, r, lat);
        check("mrst_word5_kept", r, 1);
        check("mrst_read_latency", lat, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
